// File: rtl/alpha_converge_if.sv
// Bundle between the best-action selector, the convergence stage and the
// upstream launcher: pass data in, loop-control and final policy out.
interface alpha_converge_if #(
    parameter int N_POINTS = 16,
    parameter int W        = 16
);
    logic                             i_init;
    logic                             i_start;
    logic [N_POINTS-1:0][1:0][W-1:0]  i_alpha;
    logic [N_POINTS-1:0][1:0]         i_point_action;
    logic                             o_restart;
    logic                             o_done;
    logic                             o_converged;
    logic                             o_busy;
    logic [7:0]                       o_iter_count;
    logic [W-1:0]                     o_max_delta;
    logic [N_POINTS-1:0][1:0]         o_policy_action;

    modport master (
        output i_init, i_start, i_alpha, i_point_action,
        input  o_restart, o_done, o_converged, o_busy,
               o_iter_count, o_max_delta, o_policy_action
    );

    modport slave (
        input  i_init, i_start, i_alpha, i_point_action,
        output o_restart, o_done, o_converged, o_busy,
               o_iter_count, o_max_delta, o_policy_action
    );
endinterface

// File: rtl/alpha_converge.sv
// Convergence / loop-control stage of the PBVI value-iteration pipeline.
// Captures one pass of selected alpha vectors, scans them one point per cycle
// against the previous pass, then either relaunches the pipeline or stops
// with a final policy (tolerance met or iteration cap reached).
module alpha_converge #(
    parameter int           N_POINTS = 16,
    parameter int           W        = 16,
    parameter logic [W-1:0] EPS      = 16'd4,
    parameter int           MAX_ITER = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    alpha_converge_if.slave  bus
);
    localparam int            KW       = $clog2(N_POINTS);
    localparam logic [KW-1:0] K_LAST   = KW'(N_POINTS - 1);
    localparam logic [KW-1:0] K_ONE    = KW'(1);
    localparam logic [7:0]    ITER_CAP = 8'(MAX_ITER);
    localparam logic [7:0]    ITER_SAT = 8'd255;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DECIDE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Unsigned |a-b| without wrap: larger minus smaller.
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] max_w(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    state_t                          r_state;
    state_t                          w_next_state;
    logic                            w_capture;
    logic                            w_scan_step;
    logic                            w_decide;

    logic [N_POINTS-1:0][1:0][W-1:0] r_cur;
    logic [N_POINTS-1:0][1:0][W-1:0] r_prev;
    logic [N_POINTS-1:0][1:0]        r_policy;
    logic [KW-1:0]                   r_k;
    logic [W-1:0]                    r_run_max;
    logic                            r_prev_valid;
    logic                            r_restart;
    logic                            r_done;
    logic                            r_converged;
    logic                            r_busy;
    logic [7:0]                      r_iter_count;
    logic [W-1:0]                    r_max_delta;

    logic [W-1:0]                    w_d0;
    logic [W-1:0]                    w_d1;
    logic [W-1:0]                    w_run_next;
    logic [7:0]                      w_iter_inc;
    logic                            w_conv_hit;
    logic                            w_cap_hit;

    // Per-point distance, running max and the two decision conditions.
    always_comb begin
        w_d0       = abs_diff(r_cur[r_k][0], r_prev[r_k][0]);
        w_d1       = abs_diff(r_cur[r_k][1], r_prev[r_k][1]);
        w_run_next = max_w(r_run_max, max_w(w_d0, w_d1));
        w_iter_inc = (r_iter_count == ITER_SAT) ? ITER_SAT : (r_iter_count + 8'd1);
        w_conv_hit = r_prev_valid && (r_run_max <= EPS);
        w_cap_hit  = (w_iter_inc == ITER_CAP);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-state datapath strobes; init overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_scan_step  = 1'b0;
        w_decide     = 1'b0;
        if (bus.i_init) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE, WAIT: begin
                    if (bus.i_start) begin
                        w_capture    = 1'b1;
                        w_next_state = SCAN;
                    end else begin
                        w_next_state = r_state;
                    end
                end
                SCAN: begin
                    w_scan_step = 1'b1;
                    if (r_k == K_LAST) begin
                        w_next_state = DECIDE;
                    end else begin
                        w_next_state = SCAN;
                    end
                end
                DECIDE: begin
                    w_decide = 1'b1;
                    if (w_conv_hit || w_cap_hit) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
                DONE: begin
                    w_next_state = DONE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // Capture, scan history update, decision outputs; init clears all but the policy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= '0;
            r_prev       <= '0;
            r_policy     <= '0;
            r_k          <= '0;
            r_run_max    <= '0;
            r_prev_valid <= 1'b0;
            r_restart    <= 1'b0;
            r_done       <= 1'b0;
            r_converged  <= 1'b0;
            r_busy       <= 1'b0;
            r_iter_count <= 8'd0;
            r_max_delta  <= '0;
        end else if (bus.i_init) begin
            r_cur        <= '0;
            r_prev       <= '0;
            r_k          <= '0;
            r_run_max    <= '0;
            r_prev_valid <= 1'b0;
            r_restart    <= 1'b0;
            r_done       <= 1'b0;
            r_converged  <= 1'b0;
            r_busy       <= 1'b0;
            r_iter_count <= 8'd0;
            r_max_delta  <= '0;
        end else begin
            r_restart <= 1'b0;
            r_busy    <= (w_next_state == SCAN) || (w_next_state == DECIDE);
            if (w_capture) begin
                r_cur     <= bus.i_alpha;
                r_policy  <= bus.i_point_action;
                r_k       <= '0;
                r_run_max <= '0;
            end else if (w_scan_step) begin
                r_run_max   <= w_run_next;
                r_prev[r_k] <= r_cur[r_k];
                r_k         <= r_k + K_ONE;
            end else if (w_decide) begin
                r_iter_count <= w_iter_inc;
                r_max_delta  <= r_run_max;
                r_prev_valid <= 1'b1;
                if (w_conv_hit) begin
                    r_done      <= 1'b1;
                    r_converged <= 1'b1;
                end else if (w_cap_hit) begin
                    r_done      <= 1'b1;
                    r_converged <= 1'b0;
                end else begin
                    r_restart   <= 1'b1;
                end
            end else begin
                r_k <= r_k;
            end
        end
    end

    assign bus.o_restart       = r_restart;
    assign bus.o_done          = r_done;
    assign bus.o_converged     = r_converged;
    assign bus.o_busy          = r_busy;
    assign bus.o_iter_count    = r_iter_count;
    assign bus.o_max_delta     = r_max_delta;
    assign bus.o_policy_action = r_policy;

endmodule

// File: doc/alpha_converge.md
# alpha_converge

Convergence and loop-control stage directly downstream of the per-point best-action selector in the PBVI value-iteration pipeline. Each time the selector signals a finished pass, this block captures the 16 selected alpha vectors and actions. It compares them point-by-point against the previous pass and either re-launches the pipeline for another iteration or terminates with a final policy. The terminating condition is convergence within a tolerance or an iteration cap.

## Interface
- N_POINTS, 16, number of belief points (fixed, sizes all arrays)
- W, 16, alpha component width (unsigned)
- EPS, 16'd4, convergence tolerance on max absolute component change
- MAX_ITER, 64, iteration cap (1..255)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- init  in  1  one-cycle pulse: clear history and counters, arm for a new solve
- start  in  1  one-cycle pulse from the selector's end-of-pass flag; alpha/point_action valid this cycle only
- alpha  in  W x 2 x N_POINTS  selected alpha vector per point
- point_action  in  2 x N_POINTS  selected action per point (0..2)
- restart  out  1  one-cycle pulse: launch next iteration upstream
- done  out  1  level: solve finished, held until init
- converged  out  1  valid when done: 1 = tolerance met, 0 = cap hit
- busy  out  1  high in CAPTURE/SCAN/DECIDE
- iter_count  out  8  completed passes since init
- max_delta  out  W  largest |cur-prev| of the last completed scan
- policy_action  out  2 x N_POINTS  registered actions of the last captured pass

## Operation
- States: IDLE, SCAN, DECIDE, WAIT, DONE.
- Reset values: state IDLE. restart, done, converged, busy, iter_count, max_delta, and prev_valid are 0. policy_action, cur, and prev arrays are all 0.
- IDLE/WAIT + start: cur_alpha and policy_action load from inputs. The scan index and running max are cleared. The next state is SCAN.
- SCAN (index k = 0..15, one point per cycle):
  - d0 = |cur[k][0]-prev[k][0]| and d1 = |cur[k][1]-prev[k][1]|, both unsigned W-bit, computed as larger minus smaller.
  - The running max is updated with max(d0, d1).
  - prev[k] <= cur[k] in the same cycle, after the comparison reads the old value.
  - When k = 15, the next state is DECIDE.
- DECIDE:
  - iter_count increments and max_delta latches the running max.
  - If prev_valid = 1 and max_delta <= EPS: done = 1, converged = 1, next state DONE.
  - Otherwise, if the incremented iter_count == MAX_ITER: done = 1, converged = 0, next state DONE.
  - Otherwise: restart pulses for one cycle, next state WAIT.
  - prev_valid is set to 1 on every DECIDE exit.
- The first pass after init never converges, because prev_valid = 0.
- start is ignored in SCAN, DECIDE, and DONE.
- init (any state) acts like reset, except that it leaves policy_action unchanged. init has priority over a same-cycle start.
- iter_count saturates at 255 and does not wrap.

## Timing
- start at cycle t:
  - capture is in place at t+1, and SCAN runs t+1..t+16.
  - DECIDE is at t+17, and the registered outputs (restart/done/converged/max_delta/iter_count) are visible at t+18.
- Pass latency is 18 cycles from start to decision.
- restart is high for exactly 1 cycle (t+18). The next start can arrive at t+19 or later.
- busy is high t+1..t+17.
- done/converged are stable from t+18 until init or reset.
- Asynchronous reset mid-SCAN aborts immediately. All outputs return to their reset values and no restart is issued.

## Test plan
- First pass:
  - Stimulus: init, then start with all alpha = 16'h0100, actions = 1.
  - Required response: at t+18, restart = 1, done = 0, iter_count = 1, max_delta = 16'h0100 (prev is 0), policy_action all 1.
- Identical second pass:
  - Stimulus: start again with the same data.
  - Required response: done = 1, converged = 1, iter_count = 2, max_delta = 0, no restart pulse.
- Tolerance boundary:
  - Stimulus: a second pass where point 7 component 1 changes by 4 (EPS).
  - Required response: converged = 1.
  - Stimulus: a rerun where the change is 5.
  - Required response: restart, max_delta = 5, done = 0.
- Cap:
  - Stimulus: MAX_ITER = 3, with alpha alternating 0/100 each pass.
  - Required response: restart after passes 1 and 2; after pass 3, done = 1, converged = 0, iter_count = 3.
- Ignored start and abort:
  - Stimulus: a start pulse at t+5 during SCAN.
  - Required response: no effect, and the decision still lands at t+18.
  - Stimulus: init at t+10.
  - Required response: state IDLE next cycle, iter_count = 0, busy = 0, no restart.
- Async reset:
  - Stimulus: rst_n low mid-SCAN.
  - Required response: all outputs 0 immediately. After release, a fresh start behaves as a first pass.
